// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multi-cycle MIPS datapath
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             PCWrite_o,
    output logic             PCWriteCond_o,
    output logic             IorD_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             IRWrite_o,
    output logic             MemtoReg_o,
    output logic             RegDst_o,
    output logic             RegWrite_o,
    output logic             ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic [1:0]       PCSource_o,
    output logic [1:0]       ALUOp_o,
    output logic [3:0]       state_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    // Strobes before reset gating; they must never fire while reset is held.
    logic pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal;

    // State and retired-instruction counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and Moore output decode; FETCH strobes and illegal also look at inputs.
    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        IorD_o        = 1'b0;
        MemtoReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        PCSource_o    = 2'b00;
        ALUOp_o       = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ALUSrcB_o = 2'b01;
                ALUOp_o   = 2'b10;
                if (mem_ready_i) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB_o = 2'b11;
                ALUOp_o   = 2'b10;
                case (opcode_i)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_R:             state_d = S_EXEC;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_ADDI, OP_ORI:  state_d = S_IEXEC;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALUOp_o   = 2'b10;
                state_d   = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                IorD_o   = 1'b1;
                if (mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                MemtoReg_o = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                IorD_o    = 1'b1;
                if (mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = 2'b00;
                state_d   = S_RWB;
            end
            S_RWB: begin
                RegDst_o  = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = 2'b11;
                pc_write_cond = 1'b1;
                PCSource_o    = 2'b01;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                PCSource_o = 2'b10;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALUOp_o   = (opcode_i == OP_ORI) ? 2'b01 : 2'b10;
                state_d   = S_IWB;
            end
            S_IWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        cnt_d = retire ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    end

    assign PCWrite_o     = pc_write      & rst_i;
    assign PCWriteCond_o = pc_write_cond & rst_i;
    assign MemRead_o     = mem_read      & rst_i;
    assign MemWrite_o    = mem_write     & rst_i;
    assign IRWrite_o     = ir_write      & rst_i;
    assign RegWrite_o    = reg_write     & rst_i;
    assign illegal_o     = illegal       & rst_i;
    assign state_o       = state_q;
    assign instr_cnt_o   = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

    localparam int CW = 4;
    localparam logic [16:0] STROBE_MASK = 17'b11011100100000001;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [5:0]    opcode_i;
    logic          mem_ready_i;
    logic          PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
    logic          MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, illegal_o;
    logic [1:0]    ALUSrcB_o, PCSource_o, ALUOp_o;
    logic [3:0]    state_o;
    logic [CW-1:0] instr_cnt_o;
    logic [16:0]   act_vec, ev;

    int checks = 0;
    int failures = 0;
    int chk_mode = 0;
    int exp_state = 0;
    int model_cnt = 0;
    int ill_cycles = 0;
    int trace[$];
    logic [16:0] vtrace[$];

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
        .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o),
        .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
        .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
        .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .PCSource_o(PCSource_o),
        .ALUOp_o(ALUOp_o), .state_o(state_o), .illegal_o(illegal_o),
        .instr_cnt_o(instr_cnt_o)
    );

    assign act_vec = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
                      MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, PCSource_o,
                      ALUOp_o, illegal_o};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                          6'b001000, 6'b001101};
    endfunction

    // Output table per state, as the control signal list describes it.
    function automatic logic [16:0] spec_out(input int st, input logic rdy,
                                             input logic [5:0] op, input logic rstn);
        logic pcw, pwc, iord, mr, mw, irw, m2r, rd, rw, srca, ill;
        logic [1:0] srcb, pcs, aop;
        {pcw, pwc, iord, mr, mw, irw, m2r, rd, rw, srca, ill} = '0;
        srcb = 2'b00; pcs = 2'b00; aop = 2'b00;
        case (st)
            0:  begin mr = 1; srcb = 2'b01; aop = 2'b10; irw = rdy; pcw = rdy; end
            1:  begin srcb = 2'b11; aop = 2'b10; ill = !is_legal(op); end
            2:  begin srca = 1; srcb = 2'b10; aop = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin srca = 1; end
            7:  begin rd = 1; rw = 1; end
            8:  begin srca = 1; aop = 2'b11; pwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin srca = 1; srcb = 2'b10; aop = (op == 6'b001101) ? 2'b01 : 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        if (!rstn) {pcw, pwc, mr, mw, irw, rw, ill} = '0;
        return {pcw, pwc, iord, mr, mw, irw, m2r, rd, rw, srca, srcb, pcs, aop, ill};
    endfunction

    // Single compare point, mid-cycle, against the bench's expected state and count.
    always @(negedge clk) begin
        if (chk_mode != 0) begin
            trace.push_back(int'(state_o));
            vtrace.push_back(act_vec);
            if (illegal_o) ill_cycles++;
            ev = spec_out(exp_state, mem_ready_i, opcode_i, rst_i);
            if (chk_mode == 2) begin
                chk("reset_strobes", act_vec & STROBE_MASK, ev & STROBE_MASK);
            end else begin
                chk("state", state_o, exp_state);
                chk("outputs", act_vec, ev);
                chk("count", instr_cnt_o, model_cnt);
            end
        end
    end

    // One instruction: expected state path follows from opcode and wait counts.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input int abort_after = -1);
        int sq[$];
        logic rq[$];
        bit aborted = 0;
        for (int i = 0; i < fw; i++) begin sq.push_back(0); rq.push_back(1'b0); end
        sq.push_back(0); rq.push_back(1'b1);
        sq.push_back(1); rq.push_back(1'($urandom_range(0, 1)));
        case (op)
            6'b000000: begin sq.push_back(6); sq.push_back(7); rq.push_back(1'b0); rq.push_back(1'b1); end
            6'b100011: begin
                sq.push_back(2); rq.push_back(1'b0);
                for (int i = 0; i < mw; i++) begin sq.push_back(3); rq.push_back(1'b0); end
                sq.push_back(3); rq.push_back(1'b1);
                sq.push_back(4); rq.push_back(1'b0);
            end
            6'b101011: begin
                sq.push_back(2); rq.push_back(1'b0);
                for (int i = 0; i < mw; i++) begin sq.push_back(5); rq.push_back(1'b0); end
                sq.push_back(5); rq.push_back(1'b1);
            end
            6'b000100: begin sq.push_back(8); rq.push_back(1'b0); end
            6'b000010: begin sq.push_back(9); rq.push_back(1'b0); end
            6'b001000, 6'b001101: begin
                sq.push_back(10); sq.push_back(11); rq.push_back(1'b0); rq.push_back(1'b0);
            end
            default: ;
        endcase
        trace.delete();
        vtrace.delete();
        ill_cycles = 0;
        opcode_i = op;
        for (int i = 0; i < sq.size(); i++) begin
            if (i == abort_after) begin aborted = 1; break; end
            mem_ready_i = rq[i];
            exp_state = sq[i];
            chk_mode = 1;
            @(posedge clk); #1;
        end
        if (!aborted && is_legal(op)) model_cnt = (model_cnt + 1) % (1 << CW);
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b0;
        mem_ready_i = 1'b1;
        chk_mode = 2;
        @(posedge clk); #1;
        model_cnt = 0;
        for (int i = 1; i < n; i++) begin
            exp_state = 0;
            chk_mode = 1;
            @(posedge clk); #1;
        end
        rst_i = 1'b1;
        exp_state = 0;
    endtask

    initial begin
        int exp_r[4];
        int exp_lw[7];
        exp_r  = '{0, 1, 6, 7};
        exp_lw = '{0, 1, 2, 3, 3, 3, 4};
        rst_i = 1'b0;
        opcode_i = 6'b000000;
        mem_ready_i = 1'b1;

        do_reset(2);
        #1;
        chk("rst_state", state_o, 0);
        chk("rst_cnt", instr_cnt_o, 0);
        chk("first_memread", MemRead_o, 1);
        chk("first_irwrite", IRWrite_o, 1);
        chk("first_pcwrite", PCWrite_o, 1);

        run_instr(6'b000000, 0, 0);
        chk("r_len", trace.size(), 4);
        for (int i = 0; i < 4; i++) chk("r_trace", trace[i], exp_r[i]);
        chk("r_exec_aluop", vtrace[2][2:1], 2'b00);
        chk("r_rwb_regdst", vtrace[3][9], 1);
        chk("r_rwb_regwrite", vtrace[3][8], 1);
        chk("r_back_fetch", state_o, 0);
        chk("r_cnt", instr_cnt_o, 1);

        run_instr(6'b100011, 0, 2);
        chk("lw_len", trace.size(), 7);
        for (int i = 0; i < 7; i++) chk("lw_trace", trace[i], exp_lw[i]);
        chk("lw_memrd_iord", vtrace[3][14], 1);
        chk("lw_memwb_memtoreg", vtrace[6][10], 1);
        chk("lw_cnt", instr_cnt_o, 2);

        run_instr(6'b001101, 0, 0);
        chk("ori_iexec_aluop", vtrace[2][2:1], 2'b01);
        run_instr(6'b000100, 0, 0);
        chk("beq_aluop", vtrace[2][2:1], 2'b11);
        chk("beq_pcwritecond", vtrace[2][15], 1);
        chk("ori_beq_cnt", instr_cnt_o, 4);

        run_instr(6'b111111, 0, 0);
        chk("ill_len", trace.size(), 2);
        chk("ill_pulses", ill_cycles, 1);
        chk("ill_back_fetch", state_o, 0);
        chk("ill_cnt", instr_cnt_o, 4);

        run_instr(6'b001000, 2, 0);
        run_instr(6'b101011, 0, 1);
        run_instr(6'b000000, 1, 0);
        chk("mix_cnt", instr_cnt_o, 7);

        while (model_cnt != (1 << CW) - 1) run_instr(6'b000010, 0, 0);
        chk("preload_cnt", instr_cnt_o, (1 << CW) - 1);
        run_instr(6'b000010, 0, 0);
        chk("wrap_cnt", instr_cnt_o, 0);

        run_instr(6'b101011, 0, 1, 4);
        rst_i = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        chk("abort_in_memwr", state_o, 5);
        chk("abort_memwrite_low", MemWrite_o, 0);
        do_reset(2);
        #1;
        chk("abort_state", state_o, 0);
        chk("abort_cnt", instr_cnt_o, 0);
        run_instr(6'b000000, 0, 0);
        chk("post_abort_cnt", instr_cnt_o, 1);

        chk_mode = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
